bdeser: RTL and testbench
=========================

Name: bdeser

Overview:
Serial-to-parallel byte receiver and the receive-side counterpart of bser. Samples a one-bit-per-clock serial line and detects a start bit. Shifts in WIDTH data bits LSB first, with optional parity, then checks the stop bit. Presents the assembled word on a parallel port with a one-cycle done pulse, a valid/rd hold handshake, and error flags.

Parameters:
WIDTH, 8, number of data bits per frame
PARITY, 0, 0 = no parity bit, 1 = even parity, 2 = odd parity

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  receiver enable; low forces IDLE
in  input  1  serial line; idles high
rd  input  1  consumer acknowledge; clears valid when sampled high
out  output  WIDTH  last received data word
done  output  1  one-cycle pulse at end of every completed frame, good or bad
valid  output  1  out holds an unread good word
perr  output  1  parity error on the frame just completed; valid with done
ferr  output  1  framing error (stop bit = 0) on the frame just completed; valid with done
ovr  output  1  sticky overrun flag

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, bit counter=0, shift register=0, out=0, done=0, valid=0, perr=0, ferr=0, ovr=0. Reset mid-frame discards the partial frame, with no done.
- One bit per clock. No oversampling. Line is sampled at each rising edge.
- States:
  - IDLE: if en=1 and in=0, go to DATA with counter=0. Otherwise stay.
  - DATA: shift register receives in at bit position counter (LSB first), then counter increments. After WIDTH bits, go to PAR if PARITY!=0, else STOP.
  - PAR: capture parity bit, then go to STOP.
  - STOP: sample in and evaluate the frame, then go to IDLE.
- Frame timing: start bit at edge 0, data at edges 1..WIDTH, parity at edge WIDTH+1 if enabled, stop at the next edge. done is high for exactly the one cycle after the stop-bit edge.
- Frame evaluation at the stop edge:
  - ferr=1 if in=0.
  - perr=1 if PARITY!=0 and the received parity mismatches the chosen sense over data bits plus parity bit. Even parity means the total count of ones is even.
  - Good frame (ferr=0, perr=0): out loads the shift register and valid=1.
  - Bad frame: out and valid are unchanged.
  - done=1 in both cases.
  - perr/ferr reflect this frame and hold until the next done or rst.
- Back-to-back frames: IDLE is entered after stop. A start bit on the very next edge is accepted, giving a minimum frame period of WIDTH+2 (+1 with parity) cycles.
- en low in any state: go to IDLE on that edge and abort the partial frame, with no done and no flag change. out/valid/ovr are unaffected.
- valid/rd handshake:
  - rd=1 with valid=1 clears valid.
  - rd while valid=0 is ignored.
  - A good-frame load in the same cycle as rd: load wins, valid stays 1, no overrun.
  - A good-frame load while valid=1 and rd=0 overwrites out and sets ovr.
  - ovr is cleared only by rst.
- out is stable except on good-frame loads.
- Start detection requires in=0 in IDLE only. A low line during STOP is a framing error, not a new start.

Test Plan:
1. Reset, en=1, line idle high, then serial 0,1,1,1,0,1,0,0,0,1 (PARITY=0) -> done pulses one cycle after the stop bit, out=8'h17, valid=1, perr=0, ferr=0. Then rd=1 for one cycle -> valid=0, out stays 8'h17.
2. Same frame with the stop bit=0 -> done=1, ferr=1, out remains previous value, valid unchanged. Next good frame 8'hA5 -> ferr=0, out=8'hA5.
3. PARITY=1, frame 8'h17 with parity bit 0 -> out=8'h17, perr=0. Parity bit 1 -> perr=1, out not updated. With PARITY=2, parity bit 1 for 8'h17 -> perr=0.
4. Two back-to-back good frames 8'h01 then 8'h02 with no rd -> two done pulses spaced 10 cycles apart, out=8'h02, ovr=1, valid=1. Repeat with rd asserted in the second load cycle -> ovr stays 0, valid=1.
5. Abort and reset: drop en after 4 data bits -> no done, returns to IDLE, then the next full frame 8'h3C is received correctly. Assert rst mid-frame -> all outputs 0 the next cycle, and no done for the interrupted frame.
6. Idle robustness: en=0 with a toggling line -> no state change. en=1 with the line held high for 50 cycles -> no done.

Source files
------------

// File: rtl/bdeser_if.sv
// Parallel/serial handshake bundle for the bdeser receiver.
interface bdeser_if #(parameter int WIDTH = 8);
  logic             en;
  logic             in;
  logic             rd;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             valid;
  logic             perr;
  logic             ferr;
  logic             ovr;

  modport master (output en, in, rd,
                  input  out, done, valid, perr, ferr, ovr);
  modport slave  (input  en, in, rd,
                  output out, done, valid, perr, ferr, ovr);
endinterface

// File: rtl/bdeser.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB first,
// optional parity, stop bit; one bit per clock, no oversampling.
module bdeser #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic clk,
  input  logic rst,
  bdeser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic             par_bit;
  logic [WIDTH-1:0] out_q;
  logic             done_q, valid_q, perr_q, ferr_q, ovr_q;

  logic frame_end, ones_odd, perr_now, ferr_now, good;

  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (!bus.in) state_nxt = DATA;
        DATA: if (cnt == CW'(WIDTH - 1)) state_nxt = (PARITY != 0) ? PAR : STOP;
        PAR:  state_nxt = STOP;
        STOP: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame evaluation happens combinationally on the stop-bit edge.
  always_comb begin
    frame_end = bus.en && (state == STOP);
    ones_odd  = (^sh) ^ par_bit;
    ferr_now  = !bus.in;
    case (PARITY)
      1:       perr_now = ones_odd;
      2:       perr_now = !ones_odd;
      default: perr_now = 1'b0;
    endcase
    good = frame_end && !ferr_now && !perr_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= frame_end;
      if (bus.en) begin
        case (state)
          IDLE: if (!bus.in) cnt <= '0;
          DATA: begin
            sh[cnt] <= bus.in;
            cnt     <= cnt + 1'b1;
          end
          PAR:  par_bit <= bus.in;
          default: ;
        endcase
      end
      if (frame_end) begin
        perr_q <= perr_now;
        ferr_q <= ferr_now;
      end
      // A good load beats a simultaneous rd; overrun only when the old word was unread.
      if (good) begin
        out_q   <= sh;
        valid_q <= 1'b1;
        if (valid_q && !bus.rd) ovr_q <= 1'b1;
      end else if (bus.rd) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.perr  = perr_q;
  assign bus.ferr  = ferr_q;
  assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_bdeser.sv
// Randomized frame-level bench for bdeser; instance d runs with PARITY=d.
module tb_bdeser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en_v[3];
  logic in_v[3];
  logic rd_v[3];

  bdeser_if #(.WIDTH(8)) bus0 ();
  bdeser_if #(.WIDTH(8)) bus1 ();
  bdeser_if #(.WIDTH(8)) bus2 ();

  assign bus0.en = en_v[0]; assign bus0.in = in_v[0]; assign bus0.rd = rd_v[0];
  assign bus1.en = en_v[1]; assign bus1.in = in_v[1]; assign bus1.rd = rd_v[1];
  assign bus2.en = en_v[2]; assign bus2.in = in_v[2]; assign bus2.rd = rd_v[2];

  bdeser #(.WIDTH(8), .PARITY(0)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  bdeser #(.WIDTH(8), .PARITY(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  bdeser #(.WIDTH(8), .PARITY(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Reference model: frame-level view of the parallel side.
  logic [7:0] m_out[3];
  logic       m_valid[3], m_perr[3], m_ferr[3], m_ovr[3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int d = 0; d < 3; d++) begin
      m_out[d] = '0; m_valid[d] = 0; m_perr[d] = 0; m_ferr[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic verify(input int d, input string tag, input logic edone);
    logic [7:0] o;
    logic dn, v, pe, fe, ov;
    case (d)
      0: begin o = bus0.out; dn = bus0.done; v = bus0.valid; pe = bus0.perr; fe = bus0.ferr; ov = bus0.ovr; end
      1: begin o = bus1.out; dn = bus1.done; v = bus1.valid; pe = bus1.perr; fe = bus1.ferr; ov = bus1.ovr; end
      default: begin o = bus2.out; dn = bus2.done; v = bus2.valid; pe = bus2.perr; fe = bus2.ferr; ov = bus2.ovr; end
    endcase
    chk($sformatf("p%0d.%s.done", d, tag),  32'(dn), 32'(edone));
    chk($sformatf("p%0d.%s.out", d, tag),   32'(o),  32'(m_out[d]));
    chk($sformatf("p%0d.%s.valid", d, tag), 32'(v),  32'(m_valid[d]));
    chk($sformatf("p%0d.%s.perr", d, tag),  32'(pe), 32'(m_perr[d]));
    chk($sformatf("p%0d.%s.ferr", d, tag),  32'(fe), 32'(m_ferr[d]));
    chk($sformatf("p%0d.%s.ovr", d, tag),   32'(ov), 32'(m_ovr[d]));
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic stop, input logic rd_stop, input string tag);
    logic b[$];
    int ones;
    logic pe, fe;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(data[i]);
    if (d != 0) b.push_back(pbit);
    b.push_back(stop);
    for (int i = 0; i < b.size(); i++) begin
      in_v[d] = b[i];
      rd_v[d] = (i == b.size() - 1) ? rd_stop : 1'b0;
      tick;
      if (i < b.size() - 1) verify(d, {tag, ".mid"}, 1'b0);
    end
    ones = $countones(data) + ((d != 0) ? int'(pbit) : 0);
    pe = (d == 1) ? (ones % 2 != 0) : (d == 2) ? (ones % 2 == 0) : 1'b0;
    fe = !stop;
    m_perr[d] = pe;
    m_ferr[d] = fe;
    if (!pe && !fe) begin
      if (m_valid[d] && !rd_stop) m_ovr[d] = 1'b1;
      m_out[d]   = data;
      m_valid[d] = 1'b1;
    end else if (rd_stop) begin
      m_valid[d] = 1'b0;
    end
    verify(d, {tag, ".end"}, 1'b1);
    in_v[d] = 1'b1;
    rd_v[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n, input logic rdv, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_v[d] = rdv;
      tick;
      if (rdv) m_valid[d] = 1'b0;
      verify(d, tag, 1'b0);
    end
    rd_v[d] = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin in_v[d] = 1'b1; rd_v[d] = 1'b0; end
    tick;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin en_v[d] = 1'b0; in_v[d] = 1'b1; rd_v[d] = 1'b0; end
    model_reset();
    tick; tick;
    for (int d = 0; d < 3; d++) verify(d, "reset", 1'b0);
    rst = 1'b0;

    // Basic PARITY=0 frames, read, framing error, overrun.
    en_v[0] = 1'b1;
    idle(0, 2, 1'b0, "idle0");
    send_frame(0, 8'h17, 1'b0, 1'b1, 1'b0, "f17");
    idle(0, 1, 1'b1, "rd17");
    send_frame(0, 8'h17, 1'b0, 1'b0, 1'b0, "ferr");
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, "fA5");
    idle(0, 1, 1'b1, "rdA5");
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b0, "b2b1");
    send_frame(0, 8'h02, 1'b0, 1'b1, 1'b0, "b2b2");
    do_reset();
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b0, "b2bA");
    send_frame(0, 8'h02, 1'b0, 1'b1, 1'b1, "b2bB");

    // Abort via en mid-frame, then a clean frame.
    in_v[0] = 1'b0; tick; verify(0, "ab.start", 1'b0);
    for (int i = 0; i < 4; i++) begin in_v[0] = 1'(i & 1); tick; verify(0, "ab.bit", 1'b0); end
    en_v[0] = 1'b0; in_v[0] = 1'b1; tick; verify(0, "ab.drop", 1'b0);
    en_v[0] = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, "f3C");

    // Reset mid-frame: everything clears, no done for the partial frame.
    in_v[0] = 1'b0; tick;
    in_v[0] = 1'b1; tick;
    rst = 1'b1; tick; model_reset(); rst = 1'b0;
    verify(0, "rstmid", 1'b0);
    idle(0, 12, 1'b0, "postrst");

    // en low with a toggling line, then a long idle-high stretch.
    en_v[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin in_v[0] = 1'(i & 1); tick; verify(0, "enlow", 1'b0); end
    en_v[0] = 1'b1; in_v[0] = 1'b1;
    idle(0, 50, 1'b0, "hold");
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b0, "alive");
    en_v[0] = 1'b0;

    // Parity instances.
    en_v[1] = 1'b1; en_v[2] = 1'b1;
    send_frame(1, 8'h17, 1'b0, 1'b1, 1'b0, "ev.ok");
    send_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0, "ev.bad");
    send_frame(2, 8'h17, 1'b1, 1'b1, 1'b0, "od.ok");
    send_frame(2, 8'h96, 1'b0, 1'b1, 1'b0, "od.bad");

    // Randomized traffic on all three instances.
    for (int d = 0; d < 3; d++) begin
      en_v[d] = 1'b1;
      for (int k = 0; k < 40; k++) begin
        send_frame(d, 8'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                   1'($urandom), "rnd");
        idle(d, $urandom_range(0, 3), 1'($urandom), "rgap");
      end
      en_v[d] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
